// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: size codes, FSM state
// encoding and the alignment rule used at request acceptance.
package mem_access_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Halfwords need an even address, words a word-aligned one; the
    // reserved size code 11 is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane logic: extracts and extends a sub-word from a memory
// word for loads, and merges store data into a word for read-modify-write.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              zero_ext,
    output logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the little-endian lane, then sign- or zero-extend.
    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: rdata = zero_ext ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata = zero_ext ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: rdata = word;
        endcase
    end

    // Store path: replace only the addressed lane(s) of the word just read.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Turns byte/half/word requests into
// word-wide memory accesses (read-modify-write for sub-word stores) and
// returns extended load data. Every output is a flop.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int len_data = 32,
    parameter int ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [len_data-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [len_data-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [len_data-1:0] mem_wdata,
    output logic                mem_wr,
    output logic                mem_rd,
    input  logic [len_data-1:0] mem_rdata
);

    state_t state;
    state_t next_state;

    logic                accept;
    logic                op_we;
    logic [1:0]          op_size;
    logic                op_unsigned;
    logic [1:0]          op_lane;
    logic [len_data-1:0] op_wdata;

    logic [len_data-1:0] lane_rdata;
    logic [len_data-1:0] lane_merged;

    logic                req_ready_d;
    logic                rsp_valid_d;
    logic                rsp_err_d;
    logic [len_data-1:0] rsp_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [len_data-1:0] mem_wdata_d;
    logic                mem_wr_d;
    logic                mem_rd_d;

    assign accept = req_valid && (state == ST_IDLE);

    // The lane unit always works on the live memory word; its results are
    // only registered at the end of READ, when mem_rdata is valid.
    byte_lane_unit u_lane (
        .word     (mem_rdata),
        .wdata    (op_wdata),
        .size     (op_size),
        .lane     (op_lane),
        .zero_ext (op_unsigned),
        .rdata    (lane_rdata),
        .merged   (lane_merged)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state: misaligned goes straight to RESP, word stores skip READ.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) next_state = ST_RESP;
                    else if (!req_we)                           next_state = ST_READ;
                    else if (req_size == SZ_WORD)               next_state = ST_WRITE;
                    else                                        next_state = ST_READ;
                end
            end
            ST_READ:  next_state = op_we ? ST_WRITE : ST_RESP;
            ST_WRITE: next_state = ST_RESP;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode: values the output flops take for the coming state, so
    // strobes are high exactly while the FSM sits in READ / WRITE / RESP.
    always_comb begin
        req_ready_d = (next_state == ST_IDLE);
        rsp_valid_d = (next_state == ST_RESP);
        rsp_err_d   = (state == ST_IDLE) && (next_state == ST_RESP);
        mem_rd_d    = (next_state == ST_READ);
        mem_wr_d    = (next_state == ST_WRITE);
        rsp_rdata_d = (state == ST_READ && !op_we) ? lane_rdata : '0;
        mem_addr_d  = accept ? req_addr[ADDR_W+1:2] : mem_addr;
        mem_wdata_d = mem_wdata;
        if (accept && req_we && req_size == SZ_WORD) mem_wdata_d = req_wdata;
        else if (state == ST_READ && op_we)          mem_wdata_d = lane_merged;
    end

    // Output registers; async clear drops mem_rd/mem_wr without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Request capture; pure data, only meaningful while a transaction runs.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_we       <= req_we;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            op_lane     <= req_addr[1:0];
            op_wdata    <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory sampled on negedge with one-cycle
// reads, a request-level reference model, directed table and random traffic.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    int n_vec  = 0;
    int n_fail = 0;
    int overlap_cnt = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: samples strobes on negedge, read data ready by next posedge.
    always @(negedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_rd && mem_wr) overlap_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Request-level reference: what one access should return and do to memory.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [9:0] addr, input logic [31:0] wdata,
                              output logic [31:0] e_rdata, output logic e_err, output int e_lat,
                              output int e_nrd, output int e_nwr, output logic [31:0] e_wword);
        int unsigned sh, bits, mask, word, val;
        int idx;
        idx  = int'(addr >> 2);
        sh   = 32'(addr[1:0]) * 8;
        e_err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        e_rdata = 0; e_wword = 0; e_nrd = 0; e_nwr = 0; e_lat = 1;
        if (!e_err) begin
            bits = 32'd8 << size;
            mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 1);
            word = ref_mem[idx];
            if (!we) begin
                val = (word >> sh) & mask;
                if (!uns && bits < 32 && val > (mask >> 1)) val = val | ~mask;
                e_rdata = val;
                e_nrd = 1;
                e_lat = 2;
            end else begin
                e_nwr = 1;
                if (bits == 32) begin
                    e_wword = wdata;
                    e_lat = 2;
                end else begin
                    e_wword = (word & ~(mask << sh)) | ((wdata & mask) << sh);
                    e_nrd = 1;
                    e_lat = 3;
                end
                ref_mem[idx] = e_wword;
            end
        end
    endtask

    // Issue one request from the posedge+1 phase and observe it to completion.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [9:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int nrd, output int nwr, output logic [31:0] wword);
        int   guard;
        logic addr_ok;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; rdata = 0; err = 0; wword = 0; addr_ok = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (mem_rd) nrd++;
            if (mem_wr) begin nwr++; wword = mem_wdata; end
            if ((mem_rd || mem_wr) && mem_addr != addr[9:2]) addr_ok = 1'b0;
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, ".mem_addr"}, 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] rd, ww, e_rd, e_ww;
        logic        er, e_er;
        int          lat, nrd, nwr, e_lat, e_nrd, e_nwr;
        int          ready_cyc, rsp1, lat2;
        logic [31:0] rdata2;
        string       tag;

        tbl[0]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,         32'h8899AABB, 1'b0, 2, 32'h0};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 10'h011, 32'h0,         32'hFFFFFFAA, 1'b0, 2, 32'h0};
        tbl[2]  = '{1'b0, 2'b00, 1'b1, 10'h011, 32'h0,         32'h000000AA, 1'b0, 2, 32'h0};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 10'h012, 32'h0,         32'hFFFF8899, 1'b0, 2, 32'h0};
        tbl[4]  = '{1'b0, 2'b01, 1'b1, 10'h012, 32'h0,         32'h00008899, 1'b0, 2, 32'h0};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 10'h013, 32'h0,         32'hFFFFFF88, 1'b0, 2, 32'h0};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 10'h012, 32'h12345655, 32'h0,        1'b0, 3, 32'h8855AABB};
        tbl[7]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,         32'h8855AABB, 1'b0, 2, 32'h0};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 10'h011, 32'hFFFF0000, 32'h0,        1'b1, 1, 32'h0};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,         32'h8855AABB, 1'b0, 2, 32'h0};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 10'h014, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 2'b01, 1'b0, 10'h016, 32'h0,         32'hFFFFDEAD, 1'b0, 2, 32'h0};
        tbl[12] = '{1'b0, 2'b00, 1'b1, 10'h014, 32'h0,         32'h000000EF, 1'b0, 2, 32'h0};
        tbl[13] = '{1'b0, 2'b11, 1'b0, 10'h010, 32'h0,         32'h0,        1'b1, 1, 32'h0};
        tbl[14] = '{1'b0, 2'b10, 1'b0, 10'h012, 32'h0,         32'h0,        1'b1, 1, 32'h0};
        tbl[15] = '{1'b1, 2'b01, 1'b0, 10'h016, 32'h00001234, 32'h0,        1'b0, 3, 32'h1234BEEF};
        tbl[16] = '{1'b0, 2'b10, 1'b0, 10'h014, 32'h0,         32'h1234BEEF, 1'b0, 2, 32'h0};

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h01010101 * 32'(i) ^ 32'h5A3C_96E1;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        mem_rdata = 32'h0;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_err",   32'(rsp_err),   32'd0);
        check("rst.rsp_rdata", rsp_rdata,      32'd0);
        check("rst.mem_rd",    32'(mem_rd),    32'd0);
        check("rst.mem_wr",    32'(mem_wr),    32'd0);
        check("rst.mem_addr",  32'(mem_addr),  32'd0);
        check("rst.mem_wdata", mem_wdata,      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle.req_ready", 32'(req_ready), 32'd1);

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            tag = $sformatf("tbl%0d", i);
            ref_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                       e_rd, e_er, e_lat, e_nrd, e_nwr, e_ww);
            run_req(tag, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                    rd, er, lat, nrd, nwr, ww);
            check({tag, ".rdata"}, rd, tbl[i].exp_rdata);
            check({tag, ".err"}, 32'(er), 32'(tbl[i].exp_err));
            check({tag, ".latency"}, 32'(lat), 32'(tbl[i].exp_lat));
            check({tag, ".n_rd"}, 32'(nrd), 32'(!tbl[i].exp_err && (!tbl[i].we || tbl[i].size != 2'b10)));
            check({tag, ".n_wr"}, 32'(nwr), 32'(tbl[i].we && !tbl[i].exp_err));
            if (tbl[i].we && !tbl[i].exp_err) check({tag, ".wdata"}, ww, tbl[i].exp_wword);
        end

        // Back-to-back: req_valid held high across SW then LW.
        ref_access(1'b1, 2'b10, 1'b0, 10'h010, 32'hCAFEF00D, e_rd, e_er, e_lat, e_nrd, e_nwr, e_ww);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 10'h010; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_we = 1'b0; req_wdata = 32'h0;
        ready_cyc = 0; rsp1 = 0;
        for (int c = 1; c <= 10 && ready_cyc == 0; c++) begin
            if (rsp_valid && rsp1 == 0) rsp1 = c;
            if (req_ready) ready_cyc = c;
            else begin @(posedge clk); #1; end
        end
        check("b2b.first_rsp_cycle", 32'(rsp1), 32'd2);
        check("b2b.ready_cycle", 32'(ready_cyc), 32'd3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat2 = 0; rdata2 = 0;
        for (int c = 1; c <= 8; c++) begin
            if (rsp_valid) begin lat2 = c; rdata2 = rsp_rdata; break; end
            @(posedge clk); #1;
        end
        check("b2b.load_latency", 32'(lat2), 32'd2);
        check("b2b.load_data", rdata2, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic        r_we, r_uns;
            logic [1:0]  r_size;
            logic [9:0]  r_addr;
            logic [31:0] r_wd;
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = 10'($urandom_range(0, 63));
            r_wd   = $urandom;
            tag = $sformatf("rnd%0d", i);
            ref_access(r_we, r_size, r_uns, r_addr, r_wd, e_rd, e_er, e_lat, e_nrd, e_nwr, e_ww);
            run_req(tag, r_we, r_size, r_uns, r_addr, r_wd, rd, er, lat, nrd, nwr, ww);
            check({tag, ".rdata"}, rd, e_rd);
            check({tag, ".err"}, 32'(er), 32'(e_er));
            check({tag, ".latency"}, 32'(lat), 32'(e_lat));
            check({tag, ".n_rd"}, 32'(nrd), 32'(e_nrd));
            check({tag, ".n_wr"}, 32'(nwr), 32'(e_nwr));
            if (e_nwr == 1) check({tag, ".wdata"}, ww, e_ww);
        end

        // Reset while an SB sits in WRITE: strobe must drop with no clock.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h012; req_wdata = 32'h000000EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid.read_phase", 32'(mem_rd), 32'd1);
        @(posedge clk); #1;
        check("rstmid.write_phase", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid.mem_wr_async", 32'(mem_wr), 32'd0);
        check("rstmid.mem_rd_async", 32'(mem_rd), 32'd0);
        rsp1 = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp1++;
        end
        rst_n = 1'b1;
        #1;
        check("rstmid.no_rsp", 32'(rsp1), 32'd0);
        check("rstmid.req_ready", 32'(req_ready), 32'd1);
        check("rstmid.word4", mem[4], ref_mem[4]);
        @(posedge clk); #1;
        check("rstmid.rsp_after", 32'(rsp_valid), 32'd0);

        // Memory image and strobe exclusivity over the whole run.
        for (int i = 0; i < 16; i++) check($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);
        check("rd_wr_overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
